logic_sweep_sched: RTL

LOGIC_SWEEP_SCHED -- requirements
Module: logic_sweep_sched

---
 rtl/logic_sweep_sched_if.sv | 30 +++
 rtl/logic_sweep_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/logic_sweep_sched_if.sv
// Requester and sweep signal bundle for logic_sweep_sched.
// master: the environment driving requests; slave: the scheduler.
interface logic_sweep_sched_if;
    logic       req_a;
    logic [7:0] vec_a;
    logic       gnt_a;
    logic       res_a;
    logic       req_b;
    logic [7:0] vec_b;
    logic       gnt_b;
    logic       res_b;
    logic       sweep_start;
    logic       sweep_busy;
    logic       sweep_done;
    logic [8:0] ones_count;
    logic [7:0] first_hit;
    logic       hit_valid;

    modport master (
        output req_a, vec_a, req_b, vec_b, sweep_start,
        input  gnt_a, res_a, gnt_b, res_b,
        input  sweep_busy, sweep_done, ones_count, first_hit, hit_valid
    );

    modport slave (
        input  req_a, vec_a, req_b, vec_b, sweep_start,
        output gnt_a, res_a, gnt_b, res_b,
        output sweep_busy, sweep_done, ones_count, first_hit, hit_valid
    );
endinterface

// File: rtl/logic_sweep_sched.sv
// Shared single-evaluator scheduler: two round-robin requesters share one
// instance of f(v); an exhaustive 256-vector sweep borrows the evaluator and
// blocks requesters until it has finished.
module logic_sweep_sched (
    input  logic                 clk,
    input  logic                 rst,
    logic_sweep_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // The one boolean function this block evaluates.
    function automatic logic f_eval(input logic [7:0] v);
        f_eval = v[7] & (v[0] | v[3]) & (v[4] | v[6]) & ((v[1] & v[2]) | v[5] | v[6]);
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ptr_q, ptr_d;          // 0: A has priority, 1: B has priority
    logic       gnt_a_q, gnt_a_d;
    logic       res_a_q, res_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       res_b_q, res_b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [8:0] ones_q, ones_d;
    logic [7:0] first_q, first_d;
    logic       hit_q, hit_d;

    logic       grant_a_s;
    logic       grant_b_s;
    logic [7:0] eval_vec_s;
    logic       eval_res_s;

    // Round-robin decision between the two requesters.
    always_comb begin
        grant_a_s = bus.req_a & (~bus.req_b | ~ptr_q);
        grant_b_s = bus.req_b & ~grant_a_s;
    end

    // Steer the single evaluator: sweep counter during SWEEP, else the winner.
    always_comb begin
        eval_vec_s = 8'h00;
        if (state_q == ST_SWEEP) begin
            eval_vec_s = cnt_q;
        end else if (grant_a_s) begin
            eval_vec_s = bus.vec_a;
        end else begin
            eval_vec_s = bus.vec_b;
        end
        eval_res_s = f_eval(eval_vec_s);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_a_d = 1'b0;
        res_a_d = 1'b0;
        gnt_b_d = 1'b0;
        res_b_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        ones_d  = ones_q;
        first_d = first_q;
        hit_d   = hit_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.sweep_start) begin
                    // Sweep wins over any same-cycle request; results restart.
                    state_d = ST_SWEEP;
                    cnt_d   = 8'h00;
                    ones_d  = 9'd0;
                    first_d = 8'h00;
                    hit_d   = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    gnt_a_d = grant_a_s;
                    res_a_d = grant_a_s & eval_res_s;
                    gnt_b_d = grant_b_s;
                    res_b_d = grant_b_s & eval_res_s;
                    if (grant_a_s) begin
                        ptr_d = 1'b1;
                    end else if (grant_b_s) begin
                        ptr_d = 1'b0;
                    end else begin
                        ptr_d = ptr_q;
                    end
                end
            end
            ST_SWEEP: begin
                if (eval_res_s) begin
                    ones_d = ones_q + 9'd1;
                    if (!hit_q) begin
                        first_d = cnt_q;
                        hit_d   = 1'b1;
                    end else begin
                        first_d = first_q;
                        hit_d   = hit_q;
                    end
                end else begin
                    ones_d = ones_q;
                end
                if (cnt_q == 8'hFF) begin
                    // Last vector: stop without wrapping into a second pass.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 8'd1;
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 8'h00;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'h00;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'h00;
            ptr_q   <= 1'b0;
            gnt_a_q <= 1'b0;
            res_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            res_b_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ones_q  <= 9'd0;
            first_q <= 8'h00;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_a_q <= gnt_a_d;
            res_a_q <= res_a_d;
            gnt_b_q <= gnt_b_d;
            res_b_q <= res_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ones_q  <= ones_d;
            first_q <= first_d;
            hit_q   <= hit_d;
        end
    end

    assign bus.gnt_a      = gnt_a_q;
    assign bus.res_a      = res_a_q;
    assign bus.gnt_b      = gnt_b_q;
    assign bus.res_b      = res_b_q;
    assign bus.sweep_busy = busy_q;
    assign bus.sweep_done = done_q;
    assign bus.ones_count = ones_q;
    assign bus.first_hit  = first_q;
    assign bus.hit_valid  = hit_q;

endmodule
